mesi_snoop_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the shared snoop bus of the cache simulator. It grants one of N cache controllers at a time, broadcasts the winner's bus operation to all caches and collects their snoop responses over a fixed window. It then returns the combined snoop result to the requester, which uses it to pick its next MESI state (for example, E versus S on a read).

---
 rtl/mesi_snoop_arbiter_pkg.sv | 49 ++++
 rtl/mesi_snoop_arbiter_if.sv | 43 ++++
 rtl/mesi_snoop_arbiter_rr_pick.sv | 34 +++
 rtl/mesi_snoop_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_mesi_snoop_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mesi_snoop_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mesi_pkg
// Purpose  : Shared encodings for the snoop bus. The cache-side MESI
//            controllers use the same encodings, so these values must stay
//            stable.
// Contents : bus_op_t     - broadcast bus operation
//            snoop_res_t  - combined snoop response
//            arb_state_t  - snoop arbiter sequencer state
//            combine_snoop() - priority reduction HITM > HIT > NOHIT
// Revision : 1.0 - initial release
// ============================================================================
package mesi_pkg;

    typedef enum logic [1:0] {
        OP_READ       = 2'd0,
        OP_RFO        = 2'd1,
        OP_INVALIDATE = 2'd2,
        OP_WRITEBACK  = 2'd3
    } bus_op_t;

    typedef enum logic [1:0] {
        RES_NOHIT = 2'd0,
        RES_HIT   = 2'd1,
        RES_HITM  = 2'd2
    } snoop_res_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUS   = 2'd1,
        ST_SNOOP = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    // A modified copy anywhere dominates a clean copy.
    function automatic snoop_res_t combine_snoop(input logic any_hit,
                                                 input logic any_hitm);
        snoop_res_t res;
        res = RES_NOHIT;
        if (any_hitm) begin
            res = RES_HITM;
        end else if (any_hit) begin
            res = RES_HIT;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mesi_snoop_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mesi_snoop_arbiter_if
// Purpose  : Request, broadcast and snoop-response signals between the
//            snoop arbiter and the N cache controllers.
// Modports : master - arbiter side (drives gnt/done/result/bus_*)
//            slave  - cache side   (drives req*/snoop_*)
// Signals  : req, req_op, req_addr      per-cache request, op, line address
//            gnt, done, result          grant, completion pulse, snoop result
//            bus_valid/op/addr/src      broadcast strobe and payload
//            snoop_hit, snoop_hitm      per-cache snoop responses
// Revision : 1.0 - initial release
// ============================================================================
interface mesi_snoop_arbiter_if #(
    parameter int N_CACHES = 4,
    parameter int ADDR_W   = 32
) ();
    localparam int SRC_W = $clog2(N_CACHES);

    logic [N_CACHES-1:0]        req;
    logic [2*N_CACHES-1:0]      req_op;
    logic [ADDR_W*N_CACHES-1:0] req_addr;
    logic [N_CACHES-1:0]        gnt;
    logic [N_CACHES-1:0]        done;
    logic [1:0]                 result;
    logic                       bus_valid;
    logic [1:0]                 bus_op;
    logic [ADDR_W-1:0]          bus_addr;
    logic [SRC_W-1:0]           bus_src;
    logic [N_CACHES-1:0]        snoop_hit;
    logic [N_CACHES-1:0]        snoop_hitm;

    modport master (
        input  req, req_op, req_addr, snoop_hit, snoop_hitm,
        output gnt, done, result, bus_valid, bus_op, bus_addr, bus_src
    );

    modport slave (
        output req, req_op, req_addr, snoop_hit, snoop_hitm,
        input  gnt, done, result, bus_valid, bus_op, bus_addr, bus_src
    );
endinterface
`default_nettype wire

// File: rtl/mesi_snoop_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : mesi_rr_pick
// Purpose  : Combinational round-robin picker. Searches req starting at
//            ptr+1 (mod N) and returns the first set index.
// Ports    : req_i   [N]      request vector
//            ptr_i   [IDX_W]  index of the most recent winner
//            idx_o   [IDX_W]  winning index (0 when nothing requests)
//            valid_o          at least one request present
// Revision : 1.0 - initial release
// ============================================================================
module mesi_rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  wire logic [N-1:0]     req_i,
    input  wire logic [IDX_W-1:0] ptr_i,
    output logic      [IDX_W-1:0] idx_o,
    output logic                  valid_o
);
    // Walk the search order backwards so the last hit written is the one
    // nearest ptr+1; this keeps the loop free of break/disable.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = N; i >= 1; i--) begin
            if (req_i[(int'(ptr_i) + i) % N]) begin
                idx_o   = IDX_W'((int'(ptr_i) + i) % N);
                valid_o = 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/mesi_snoop_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mesi_snoop_arbiter
// Purpose  : Round-robin arbiter and sequencer for the shared snoop bus.
//            Grants one cache, broadcasts its operation for one cycle,
//            gathers snoop responses over SNOOP_LAT cycles and returns the
//            combined result with a one-cycle done pulse.
// Ports    : clk               clock, rising edge
//            reset             synchronous, active-low
//            arb (master)      request / broadcast / snoop interface
//            stat_txn  [32]    completed transactions (optional)
//            stat_hitm [32]    completions with HITM result (optional)
// Config   : MESI_SNOOP_ARB_STATS_EN - adds the stat_txn/stat_hitm counters
// Revision : 1.0 - initial release
// ============================================================================
module mesi_snoop_arbiter
    import mesi_pkg::*;
#(
    parameter int N_CACHES  = 4,
    parameter int ADDR_W    = 32,
    parameter int SNOOP_LAT = 2
) (
    input  wire logic               clk,
    input  wire logic               reset,
    mesi_snoop_arbiter_if.master    arb
`ifdef MESI_SNOOP_ARB_STATS_EN
    ,
    output logic [31:0]             stat_txn,
    output logic [31:0]             stat_hitm
`endif
);
    localparam int IDX_W = $clog2(N_CACHES);
    localparam int CNT_W = (SNOOP_LAT > 1) ? $clog2(SNOOP_LAT) : 1;
    localparam logic [N_CACHES-1:0] ONE = {{(N_CACHES-1){1'b0}}, 1'b1};

    // Sequencer and datapath registers
    arb_state_t           state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     src_q, src_d;
    bus_op_t              op_q, op_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [N_CACHES-1:0]  hit_q, hit_d;
    logic [N_CACHES-1:0]  hitm_q, hitm_d;

    // Output registers
    logic [N_CACHES-1:0]  gnt_q, gnt_d;
    logic [N_CACHES-1:0]  done_q, done_d;
    snoop_res_t           result_q, result_d;
    logic                 bus_valid_q, bus_valid_d;

    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_valid;
    logic [N_CACHES-1:0]  srcmask;

    mesi_rr_pick #(
        .N     (N_CACHES),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i   (arb.req),
        .ptr_i   (ptr_q),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    assign srcmask = ONE << src_q;

    // ------------------------------------------------------------------
    // State register (sequencer, datapath and outputs)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= IDX_W'(N_CACHES - 1);  // cache 0 searched first
            src_q       <= '0;
            op_q        <= OP_READ;
            addr_q      <= '0;
            cnt_q       <= '0;
            hit_q       <= '0;
            hitm_q      <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            result_q    <= RES_NOHIT;
            bus_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            src_q       <= src_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            hit_q       <= hit_d;
            hitm_q      <= hitm_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            result_q    <= result_d;
            bus_valid_q <= bus_valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        src_d   = src_q;
        op_d    = op_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        hit_d   = hit_q;
        hitm_d  = hitm_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    src_d   = pick_idx;
                    op_d    = bus_op_t'(arb.req_op[2*int'(pick_idx) +: 2]);
                    addr_d  = arb.req_addr[ADDR_W*int'(pick_idx) +: ADDR_W];
                    state_d = ST_BUS;
                end
            end
            ST_BUS: begin
                hit_d  = '0;
                hitm_d = '0;
                if (op_q == OP_WRITEBACK) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d   = CNT_W'(SNOOP_LAT - 1);
                    state_d = ST_SNOOP;
                end
            end
            ST_SNOOP: begin
                // The requester never snoops itself.
                hit_d  = hit_q  | (arb.snoop_hit  & ~srcmask);
                hitm_d = hitm_q | (arb.snoop_hitm & ~srcmask);
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                ptr_d   = src_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: decoded from the next state so every output leaves a
    // flop and lines up with the cycle its state is occupied.
    // ------------------------------------------------------------------
    always_comb begin
        gnt_d       = '0;
        done_d      = '0;
        result_d    = RES_NOHIT;
        bus_valid_d = (state_d == ST_BUS);
        if (state_d != ST_IDLE) begin
            gnt_d = ONE << src_d;
        end
        if (state_d == ST_RESP) begin
            done_d = ONE << src_d;
            if (op_d != OP_WRITEBACK) begin
                result_d = combine_snoop(|hit_d, |hitm_d);
            end
        end
    end

    assign arb.gnt       = gnt_q;
    assign arb.done      = done_q;
    assign arb.result    = result_q;
    assign arb.bus_valid = bus_valid_q;
    assign arb.bus_op    = op_q;
    assign arb.bus_addr  = addr_q;
    assign arb.bus_src   = src_q;

`ifdef MESI_SNOOP_ARB_STATS_EN
    logic [31:0] stat_txn_q;
    logic [31:0] stat_hitm_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_txn_q  <= '0;
            stat_hitm_q <= '0;
        end else if (state_q == ST_RESP) begin
            stat_txn_q <= stat_txn_q + 32'd1;
            if (result_q == RES_HITM) begin
                stat_hitm_q <= stat_hitm_q + 32'd1;
            end
        end
    end

    assign stat_txn  = stat_txn_q;
    assign stat_hitm = stat_hitm_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mesi_snoop_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mesi_snoop_arbiter
// Purpose  : Self-checking bench for mesi_snoop_arbiter. Directed
//            transactions push expected broadcasts and completions into
//            queues; a monitor pops and compares whenever the DUT strobes
//            bus_valid or done.
// Config   : MESI_SNOOP_ARB_STATS_EN - also checks stat_txn/stat_hitm
// Revision : 1.0 - initial release
// ============================================================================
module tb_mesi_snoop_arbiter;
    import mesi_pkg::*;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int L  = 2;

    typedef struct {
        int          src;
        logic [1:0]  op;
        logic [31:0] addr;
        logic [1:0]  res;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    exp_t bus_q[$];
    exp_t done_q[$];
    int   dcyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mesi_snoop_arbiter_if #(.N_CACHES(N), .ADDR_W(AW)) bus_if ();

`ifdef MESI_SNOOP_ARB_STATS_EN
    logic [31:0] stat_txn;
    logic [31:0] stat_hitm;
`endif

    mesi_snoop_arbiter #(
        .N_CACHES  (N),
        .ADDR_W    (AW),
        .SNOOP_LAT (L)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .arb       (bus_if)
`ifdef MESI_SNOOP_ARB_STATS_EN
        ,
        .stat_txn  (stat_txn),
        .stat_hitm (stat_hitm)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    function automatic exp_t mk(input int src, input logic [1:0] op,
                                input logic [31:0] addr, input logic [1:0] res);
        exp_t e;
        e.src  = src;
        e.op   = op;
        e.addr = addr;
        e.res  = res;
        return e;
    endfunction

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    initial begin
        exp_t e;
        int   bus_cyc;
        bus_cyc = 0;
        forever begin
            @(negedge clk);
            if (bus_if.gnt != '0)
                chk("gnt_onehot", 64'($countones(bus_if.gnt)), 64'd1);
            if (bus_if.bus_valid) begin
                if (bus_q.size() == 0) begin
                    timeout("unexpected_bus_valid");
                end else begin
                    e = bus_q.pop_front();
                    chk("bus_src",  64'(bus_if.bus_src),  64'(e.src));
                    chk("bus_op",   64'(bus_if.bus_op),   64'(e.op));
                    chk("bus_addr", 64'(bus_if.bus_addr), 64'(e.addr));
                    chk("gnt_at_bus", 64'(bus_if.gnt), 64'(4'b0001 << e.src));
                    bus_cyc = cyc;
                end
            end
            if (bus_if.done != '0) begin
                if (done_q.size() == 0) begin
                    timeout("unexpected_done");
                end else begin
                    e = done_q.pop_front();
                    chk("done_vec", 64'(bus_if.done), 64'(4'b0001 << e.src));
                    chk("gnt_at_done", 64'(bus_if.gnt), 64'(4'b0001 << e.src));
                    chk("result", 64'(bus_if.result), 64'(e.res));
                    chk("resp_latency", 64'(cyc - bus_cyc),
                        (e.op == 2'd3) ? 64'd1 : 64'(L + 1));
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Drivers
    // ------------------------------------------------------------------
    // One complete transaction from a single requester. x* patterns are
    // driven during BUS and RESP (must be ignored); p1/p2 during SNOOP.
    task automatic txn(input int idx, input logic [1:0] op, input logic [31:0] addr,
                       input logic [3:0] xh, input logic [3:0] xhm,
                       input logic [3:0] h1, input logic [3:0] hm1,
                       input logic [3:0] h2, input logic [3:0] hm2,
                       input logic [1:0] res);
        int c;
        bit seen;
        bus_q.push_back(mk(idx, op, addr, res));
        done_q.push_back(mk(idx, op, addr, res));
        bus_if.req_op[2*idx +: 2]    = op;
        bus_if.req_addr[AW*idx +: AW] = addr;
        bus_if.req[idx]              = 1'b1;
        c = 0;
        while (!bus_if.bus_valid && c < 50) begin
            @(negedge clk);
            c++;
        end
        if (!bus_if.bus_valid) begin
            timeout("wait_bus_valid");
            bus_if.req[idx] = 1'b0;
            return;
        end
        bus_if.snoop_hit  = xh;
        bus_if.snoop_hitm = xhm;
        c    = 0;
        seen = 1'b0;
        while (!seen && c < 20) begin
            @(negedge clk);
            c++;
            if (bus_if.done[idx]) begin
                seen = 1'b1;
            end else if (c == 1) begin
                bus_if.snoop_hit  = h1;
                bus_if.snoop_hitm = hm1;
            end else if (c == 2) begin
                bus_if.snoop_hit  = h2;
                bus_if.snoop_hitm = hm2;
            end else begin
                bus_if.snoop_hit  = xh;
                bus_if.snoop_hitm = xhm;
            end
        end
        if (!seen) timeout("wait_done");
        bus_if.req[idx]   = 1'b0;
        bus_if.snoop_hit  = xh;
        bus_if.snoop_hitm = xhm;
        @(negedge clk);
        bus_if.snoop_hit  = '0;
        bus_if.snoop_hitm = '0;
    endtask

    // Waits for n done pulses, recording their cycles; optionally drops the
    // matching request on each pulse.
    task automatic wait_dones(input int n, input bit drop);
        int got;
        int c;
        got = 0;
        c   = 0;
        dcyc.delete();
        while (got < n && c < 100) begin
            @(negedge clk);
            c++;
            if (bus_if.done != '0) begin
                got++;
                dcyc.push_back(cyc);
                if (drop) bus_if.req = bus_if.req & ~bus_if.done;
            end
        end
        if (got < n) timeout("wait_dones");
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int c;
        bus_if.req        = '0;
        bus_if.req_op     = '0;
        bus_if.req_addr   = '0;
        bus_if.snoop_hit  = '0;
        bus_if.snoop_hitm = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_gnt",       64'(bus_if.gnt),       64'd0);
        chk("rst_done",      64'(bus_if.done),      64'd0);
        chk("rst_result",    64'(bus_if.result),    64'd0);
        chk("rst_bus_valid", 64'(bus_if.bus_valid), 64'd0);
        chk("rst_bus_op",    64'(bus_if.bus_op),    64'd0);
        chk("rst_bus_addr",  64'(bus_if.bus_addr),  64'd0);
        chk("rst_bus_src",   64'(bus_if.bus_src),   64'd0);
`ifdef MESI_SNOOP_ARB_STATS_EN
        chk("rst_stat_txn",  64'(stat_txn),  64'd0);
        chk("rst_stat_hitm", 64'(stat_hitm), 64'd0);
`endif
        reset = 1'b1;
        @(negedge clk);

        // Single read, no hits
        txn(1, 2'd0, 32'h100, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0);
        chk("idle_gnt",       64'(bus_if.gnt),       64'd0);
        chk("idle_bus_valid", 64'(bus_if.bus_valid), 64'd0);
        chk("idle_hold_addr", 64'(bus_if.bus_addr),  64'h100);

        // Full contention held from reset: 0,1,2,3,0 every SNOOP_LAT+3
        reset = 1'b0;
        bus_if.req_op = '0;
        for (int i = 0; i < N; i++) bus_if.req_addr[AW*i +: AW] = 32'h1000 + 32'(i) * 32'h40;
        bus_if.req = 4'hF;
        for (int i = 0; i < 5; i++) begin
            bus_q.push_back(mk(i % N, 2'd0, 32'h1000 + 32'(i % N) * 32'h40, 2'd0));
            done_q.push_back(mk(i % N, 2'd0, 32'h1000 + 32'(i % N) * 32'h40, 2'd0));
        end
        @(negedge clk);
        reset = 1'b1;
        wait_dones(5, 1'b0);
        bus_if.req = '0;
        if (dcyc.size() == 5) begin
            for (int i = 1; i < 5; i++)
                chk("done_spacing", 64'(dcyc[i] - dcyc[i-1]), 64'(L + 3));
        end
        @(negedge clk);

        // HITM dominates an earlier HIT
        txn(0, 2'd1, 32'h2000, 4'h0, 4'h0, 4'b0100, 4'h0, 4'h0, 4'b1000, 2'd2);
        // Clean hit only
        txn(1, 2'd2, 32'h2040, 4'h0, 4'h0, 4'h0, 4'h0, 4'b1000, 4'h0, 2'd1);
        // Writeback skips SNOOP and always returns NOHIT
        txn(3, 2'd3, 32'h3000, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 2'd0);
        // Source's own responses are masked
        txn(2, 2'd0, 32'h4000, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 2'd0);
        // Responses during BUS/RESP are ignored (leaves ptr at cache 0)
        txn(0, 2'd0, 32'h5000, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0);

        // Reset in the middle of SNOOP
        bus_q.push_back(mk(2, 2'd0, 32'h6000, 2'd0));
        bus_if.req_op[5:4]      = 2'd0;
        bus_if.req_addr[95:64]  = 32'h6000;
        bus_if.req[2]           = 1'b1;
        c = 0;
        while (!bus_if.bus_valid && c < 50) begin
            @(negedge clk);
            c++;
        end
        if (!bus_if.bus_valid) timeout("mid_wait_bus_valid");
        @(negedge clk);
        bus_if.snoop_hitm = 4'b1000;
        reset = 1'b0;
        bus_if.req[2] = 1'b0;
        @(negedge clk);
        bus_if.snoop_hitm = '0;
        chk("mid_rst_gnt",       64'(bus_if.gnt),       64'd0);
        chk("mid_rst_done",      64'(bus_if.done),      64'd0);
        chk("mid_rst_bus_valid", 64'(bus_if.bus_valid), 64'd0);
        chk("mid_rst_result",    64'(bus_if.result),    64'd0);
        chk("mid_rst_bus_addr",  64'(bus_if.bus_addr),  64'd0);
`ifdef MESI_SNOOP_ARB_STATS_EN
        chk("mid_rst_stat_txn",  64'(stat_txn),  64'd0);
        chk("mid_rst_stat_hitm", 64'(stat_hitm), 64'd0);
`endif
        reset = 1'b1;

        // Cache 0 must beat cache 3 after reset even though the last
        // completed grant was cache 0.
        bus_if.req_op[1:0]     = 2'd0;
        bus_if.req_addr[31:0]  = 32'h7000;
        bus_if.req_op[7:6]     = 2'd1;
        bus_if.req_addr[127:96] = 32'h7300;
        bus_q.push_back(mk(0, 2'd0, 32'h7000, 2'd0));
        done_q.push_back(mk(0, 2'd0, 32'h7000, 2'd0));
        bus_q.push_back(mk(3, 2'd1, 32'h7300, 2'd0));
        done_q.push_back(mk(3, 2'd1, 32'h7300, 2'd0));
        bus_if.req = 4'b1001;
        wait_dones(2, 1'b1);
        bus_if.req = '0;
        repeat (3) @(negedge clk);
`ifdef MESI_SNOOP_ARB_STATS_EN
        chk("end_stat_txn",  64'(stat_txn),  64'd2);
        chk("end_stat_hitm", 64'(stat_hitm), 64'd0);
`endif
        chk("queues_drained", 64'(bus_q.size() + done_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
